// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core sequencer and its
// load/store alignment unit.
package core_pkg;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       wb_en;
        logic [1:0] wb_sel;
        logic [2:0] mem_op;
        logic [4:0] rd;
    } dec_t;

    typedef enum logic [2:0] {
        FETCH,
        IWAIT,
        EXEC,
        MEM,
        MWAIT,
        WB
    } state_t;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // mem_op follows the RISC-V funct3 layout: bit 2 selects zero-extension.
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane handling: byte enables, store replication,
// load shift plus sign/zero extension, and alignment fault detection.
module lsu_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        mem_op,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   ld_data,
    output logic              misalign
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    logic [OFF_W-1:0]   off;
    logic [NB-1:0]      size_mask;
    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  ld_b;
    logic signed [15:0] ld_h;
    logic signed [31:0] ld_w;

    assign off     = addr[OFF_W-1:0];
    assign shifted = rdata >> {off, 3'b000};
    assign ld_b    = shifted[7:0];
    assign ld_h    = shifted[15:0];
    assign ld_w    = shifted[31:0];

    always_comb begin
        size_mask = '0;
        misalign  = 1'b0;
        wdata     = st_data;
        case (mem_op[1:0])
            2'b00: begin
                size_mask = NB'(1'b1);
                wdata     = {NB{st_data[7:0]}};
            end
            2'b01: begin
                size_mask = NB'(2'b11);
                misalign  = addr[0];
                wdata     = {(NB/2){st_data[15:0]}};
            end
            2'b10: begin
                size_mask = NB'(4'hF);
                misalign  = |addr[1:0];
                wdata     = {(NB/4){st_data[31:0]}};
            end
            default: begin
                // A doubleword cannot be carried by a 32-bit bus at all.
                size_mask = '1;
                misalign  = (XLEN == 32) || (|addr[2:0]);
                wdata     = st_data;
            end
        endcase
        if (mem_op == 3'b111) begin
            misalign = 1'b1;
        end
        be = size_mask << off;
    end

    always_comb begin
        ld_data = shifted;
        case (mem_op)
            MEM_B:   ld_data = XLEN'(ld_b);
            MEM_H:   ld_data = XLEN'(ld_h);
            MEM_W:   ld_data = XLEN'(ld_w);
            MEM_BU:  ld_data = XLEN'(shifted[7:0]);
            MEM_HU:  ld_data = XLEN'(shifted[15:0]);
            MEM_WU:  ld_data = XLEN'(shifted[31:0]);
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, execute, optional memory access
// and register write-back, one instruction at a time.
module core_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  dec_t              dec_i,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              br_taken,
    output logic [XLEN-1:0]   pc,
    output logic [31:0]       ir,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              retire,
    output logic              misalign
);

    state_t            state, state_d;
    logic              run;
    dec_t              dec_q;
    logic              br_q;
    logic              mis_q;
    logic [XLEN/8-1:0] be_q;
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   ld_q;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   pc_next;
    logic              exec_mem;

    logic [2:0]        lsu_op;
    logic [XLEN-1:0]   lsu_addr;
    logic [XLEN/8-1:0] lsu_be;
    logic [XLEN-1:0]   lsu_wdata;
    logic [XLEN-1:0]   lsu_ld;
    logic              lsu_mis;

    // The alignment unit serves EXEC (fresh operands) and MWAIT (latched ones).
    assign lsu_op   = (state == EXEC) ? dec_i.mem_op : dec_q.mem_op;
    assign lsu_addr = (state == EXEC) ? alu_result : alu_q;
    assign exec_mem = dec_i.is_load | dec_i.is_store;
    assign pc_plus4 = pc + XLEN'(4);

    lsu_align #(
        .XLEN(XLEN)
    ) u_lsu_align (
        .mem_op   (lsu_op),
        .addr     (lsu_addr),
        .st_data  (rs2_data),
        .rdata    (dmem_rdata),
        .be       (lsu_be),
        .wdata    (lsu_wdata),
        .ld_data  (lsu_ld),
        .misalign (lsu_mis)
    );

    always_comb begin
        if (dec_q.is_jalr) begin
            pc_next = {alu_q[XLEN-1:1], 1'b0};
        end else if (dec_q.is_jal || (dec_q.is_branch && br_q)) begin
            pc_next = alu_q;
        end else begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            run   <= 1'b0;
            pc    <= RESET_PC;
            ir    <= NOP_INSN;
            dec_q <= '0;
            br_q  <= 1'b0;
            mis_q <= 1'b0;
            be_q  <= '0;
        end else begin
            // run holds off the first fetch until the cycle after release.
            run   <= 1'b1;
            state <= state_d;
            if (state == IWAIT && imem_rvalid) begin
                ir <= imem_rdata;
            end
            if (state == EXEC) begin
                dec_q <= dec_i;
                br_q  <= br_taken;
                mis_q <= exec_mem && lsu_mis;
                be_q  <= lsu_be;
            end
            if (state == WB) begin
                pc <= pc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            alu_q   <= alu_result;
            wdata_q <= lsu_wdata;
        end
        if (state == MWAIT && dmem_rvalid) begin
            ld_q <= lsu_ld;
        end
    end

    always_comb begin
        state_d    = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_be    = '0;
        retire     = 1'b0;
        misalign   = 1'b0;
        rf_we      = 1'b0;
        imem_addr  = {pc[XLEN-1:2], 2'b00};
        dmem_addr  = alu_q;
        dmem_wdata = wdata_q;
        rf_waddr   = dec_q.rd;
        case (dec_q.wb_sel)
            WB_LOAD: rf_wdata = ld_q;
            WB_PC4:  rf_wdata = pc_plus4;
            default: rf_wdata = alu_q;
        endcase

        case (state)
            FETCH: begin
                imem_req = run;
                if (run && imem_gnt) begin
                    state_d = IWAIT;
                end
            end
            IWAIT: begin
                if (imem_rvalid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = (exec_mem && !lsu_mis) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_q.is_store;
                dmem_be  = be_q;
                if (dmem_gnt) begin
                    state_d = dec_q.is_load ? MWAIT : WB;
                end
            end
            MWAIT: begin
                if (dmem_rvalid) begin
                    state_d = WB;
                end
            end
            WB: begin
                retire   = 1'b1;
                misalign = mis_q;
                rf_we    = dec_q.wb_en && (dec_q.rd != 5'd0) && !mis_q;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer with a behavioural instruction-level
// reference model and directed corner cases.
module tb_core_sequencer;
    import core_pkg::*;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    dec_t        dec_i;
    logic [31:0] alu_result, rs2_data;
    logic        br_taken;
    logic [31:0] pc, ir;
    logic        rf_we, retire, misalign;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    core_sequencer #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .dec_i(dec_i), .alu_result(alu_result), .rs2_data(rs2_data), .br_taken(br_taken),
        .pc(pc), .ir(ir), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire(retire), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] m_pc, m_ir;
    logic [31:0] cap_wdata, cap_dwdata;
    logic [3:0]  cap_be;
    logic        cap_mis, cap_dreq;
    int          cap_wb_cyc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic int sz(input logic [2:0] op);
        case (op[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit mis_f(input logic [2:0] op, input logic [31:0] a);
        int s = sz(op);
        return (s > 4) || ((int'(a[2:0]) % s) != 0);
    endfunction

    function automatic logic [3:0] be_f(input logic [2:0] op, input logic [31:0] a);
        int s = sz(op);
        return 4'(((1 << s) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] wdata_f(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] r;
        int s = sz(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] load_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
        int bits = 8 * sz(op);
        longint unsigned v, m;
        v = longint'(rd) >> (8 * int'(a[1:0]));
        m = (64'd1 << bits) - 64'd1;
        v = v & m;
        if (!op[2] && bits < 64 && ((v >> (bits - 1)) & 64'd1) == 64'd1) v = v | ~m;
        return v[31:0];
    endfunction

    task automatic run_instr(input dec_t d, input logic [31:0] alu, input logic [31:0] rs2,
                             input logic taken, input logic [31:0] insn, input logic [31:0] ldw,
                             input int gwi, input int rdi, input int gwd, input int rdd,
                             input bit glitch, input bit abort);
        logic        is_mem, mis, exp_we;
        logic [31:0] exp_pc, exp_wd;
        int          n;
        is_mem = d.is_load | d.is_store;
        mis    = is_mem && mis_f(d.mem_op, alu);
        if (d.is_jalr) exp_pc = alu & ~32'd1;
        else if (d.is_jal || (d.is_branch && taken)) exp_pc = alu;
        else exp_pc = m_pc + 32'd4;
        case (d.wb_sel)
            2'd1:    exp_wd = load_f(d.mem_op, alu, ldw);
            2'd2:    exp_wd = m_pc + 32'd4;
            default: exp_wd = alu;
        endcase
        exp_we = d.wb_en && (d.rd != 5'd0) && !mis;

        dec_i = d; alu_result = alu; rs2_data = rs2; br_taken = taken;
        n = 0;
        while (imem_req !== 1'b1 && n < 16) begin step(); n++; end
        check_val("fetch_req", imem_req, 1);
        check_val("fetch_addr", imem_addr, m_pc & ~32'd3);
        for (int i = 0; i < gwi; i++) begin
            imem_gnt = 0;
            step();
            check_val("fetch_hold_req", imem_req, 1);
            check_val("fetch_hold_addr", imem_addr, m_pc & ~32'd3);
            check_val("fetch_hold_ir", ir, m_ir);
        end
        imem_gnt = 1; imem_rvalid = glitch; imem_rdata = ~insn;
        step();
        imem_gnt = 0; imem_rvalid = 0;
        check_val("iwait_req", imem_req, 0);
        for (int i = 0; i < rdi; i++) begin
            step();
            check_val("iwait_ir", ir, m_ir);
        end
        imem_rvalid = 1; imem_rdata = insn;
        step();
        imem_rvalid = 0; imem_rdata = $urandom;
        m_ir = insn;
        check_val("ir_latch", ir, insn);
        check_val("exec_quiet", {rf_we, retire, dmem_req}, 0);
        step();
        cap_dreq = dmem_req;
        if (is_mem && !mis) begin
            check_val("mem_req", dmem_req, 1);
            check_val("mem_addr", dmem_addr, alu);
            check_val("mem_we", dmem_we, d.is_store);
            if (d.is_store) begin
                check_val("mem_be", dmem_be, be_f(d.mem_op, alu));
                check_val("mem_wdata", dmem_wdata, wdata_f(d.mem_op, rs2));
            end
            cap_be = dmem_be; cap_dwdata = dmem_wdata;
            for (int i = 0; i < gwd; i++) begin
                dmem_gnt = 0;
                step();
                check_val("mem_hold_req", dmem_req, 1);
                check_val("mem_hold_addr", dmem_addr, alu);
            end
            dmem_gnt = 1; dmem_rvalid = glitch; dmem_rdata = ~ldw;
            step();
            dmem_gnt = 0; dmem_rvalid = 0;
            if (d.is_load) begin
                check_val("mwait_req", dmem_req, 0);
                for (int i = 0; i < rdd; i++) begin
                    step();
                    check_val("mwait_rf_we", rf_we, 0);
                end
                if (abort) begin
                    reset = 0;
                    #1;
                    check_val("rst_mid_reqs", {imem_req, dmem_req, dmem_we, dmem_be}, 0);
                    check_val("rst_mid_pulses", {rf_we, retire, misalign}, 0);
                    check_val("rst_mid_pc", pc, RST_PC);
                    check_val("rst_mid_ir", ir, 32'h13);
                    step();
                    reset = 1;
                    dmem_rvalid = 1; dmem_rdata = ldw;
                    step();
                    dmem_rvalid = 0;
                    for (int i = 0; i < 3; i++) begin
                        check_val("late_rvalid_rf_we", {rf_we, retire}, 0);
                        check_val("refetch_req", imem_req, 1);
                        check_val("refetch_addr", imem_addr, RST_PC);
                        step();
                    end
                    m_pc = RST_PC; m_ir = 32'h13;
                    return;
                end
                dmem_rvalid = 1; dmem_rdata = ldw;
                step();
                dmem_rvalid = 0;
            end
        end
        check_val("wb_retire", retire, 1);
        check_val("wb_misalign", misalign, mis);
        check_val("wb_rf_we", rf_we, exp_we);
        check_val("wb_dmem_req", dmem_req, 0);
        if (exp_we) begin
            check_val("wb_waddr", rf_waddr, d.rd);
            check_val("wb_wdata", rf_wdata, exp_wd);
        end
        cap_wdata = rf_wdata; cap_mis = misalign; cap_wb_cyc = cyc;
        step();
        check_val("retire_pulse", retire, 0);
        check_val("pc_next", pc, exp_pc);
        m_pc = exp_pc;
    endtask

    task automatic run_random();
        dec_t        d;
        logic [31:0] alu;
        int          kind;
        d    = '0;
        alu  = $urandom;
        kind = $urandom_range(0, 5);
        d.rd     = 5'($urandom);
        d.wb_en  = 1'($urandom_range(0, 1));
        d.wb_sel = ($urandom_range(0, 1) == 0) ? WB_ALU : WB_PC4;
        case (kind)
            1: begin d.is_load = 1; d.wb_sel = WB_LOAD; d.mem_op = 3'($urandom_range(0, 6)); end
            2: begin d.is_store = 1; d.wb_en = 0; d.mem_op = 3'($urandom_range(0, 3)); end
            3: d.is_branch = 1;
            4: begin d.is_jal = 1; d.wb_sel = WB_PC4; end
            5: begin d.is_jalr = 1; d.wb_sel = WB_PC4; end
            default: ;
        endcase
        run_instr(d, alu, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        dec_t        d;
        logic [31:0] old_pc;
        reset = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
        dec_i = '0; alu_result = '0; rs2_data = '0; br_taken = 0;
        m_pc = RST_PC; m_ir = 32'h13;
        step(); step();
        check_val("rst_reqs", {imem_req, dmem_req, dmem_we, dmem_be}, 0);
        check_val("rst_pulses", {rf_we, retire, misalign}, 0);
        check_val("rst_pc", pc, RST_PC);
        check_val("rst_ir", ir, 32'h13);
        reset = 1;
        cyc = 1;

        d = '0; d.wb_en = 1; d.rd = 5'd5; d.wb_sel = WB_ALU;
        run_instr(d, 32'h55, 0, 0, 32'h00500293, 0, 0, 0, 0, 0, 0, 0);
        check_val("addi_wb_cycle", cap_wb_cyc, 5);
        check_val("addi_wdata", cap_wdata, 32'h55);

        d = '0;
        run_instr(d, 32'h0, 0, 0, 32'h13, 0, 3, 1, 0, 0, 0, 0);

        d = '0; d.is_load = 1; d.wb_en = 1; d.rd = 5'd6; d.wb_sel = WB_LOAD; d.mem_op = MEM_B;
        run_instr(d, 32'h103, 0, 0, 32'h10300303, 32'h80123456, 0, 0, 0, 0, 0, 0);
        check_val("lb_sext", cap_wdata, 32'hFFFFFF80);
        d.mem_op = MEM_BU;
        run_instr(d, 32'h103, 0, 0, 32'h10304303, 32'h80123456, 0, 0, 1, 1, 1, 0);
        check_val("lbu_zext", cap_wdata, 32'h00000080);

        d = '0; d.is_store = 1; d.mem_op = MEM_H;
        run_instr(d, 32'h102, 32'h1234, 0, 32'h10201123, 0, 0, 0, 0, 0, 0, 0);
        check_val("sh_be", cap_be, 4'b1100);
        check_val("sh_wdata", cap_dwdata, 32'h12341234);
        run_instr(d, 32'h101, 32'h1234, 0, 32'h10101123, 0, 0, 0, 0, 0, 0, 0);
        check_val("sh_mis_flag", cap_mis, 1);
        check_val("sh_mis_noreq", cap_dreq, 0);

        d = '0; d.is_branch = 1;
        run_instr(d, 32'h40, 0, 1, 32'h04000063, 0, 0, 0, 0, 0, 0, 0);
        check_val("br_taken_pc", pc, 32'h40);
        old_pc = m_pc;
        d = '0; d.is_jalr = 1; d.wb_en = 1; d.rd = 5'd1; d.wb_sel = WB_PC4;
        run_instr(d, 32'h41, 0, 0, 32'h041000e7, 0, 0, 0, 0, 0, 0, 0);
        check_val("jalr_pc", pc, 32'h40);
        check_val("jalr_link", cap_wdata, old_pc + 32'd4);

        d = '0; d.is_load = 1; d.wb_en = 1; d.rd = 5'd7; d.wb_sel = WB_LOAD; d.mem_op = MEM_W;
        run_instr(d, 32'h200, 0, 0, 32'h20002383, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1);

        d = '0; d.wb_en = 1; d.rd = 5'd8; d.wb_sel = WB_ALU;
        run_instr(d, 32'h77, 0, 0, 32'h07700413, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 150; k++) run_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
